// File: rtl/sim_ram_for_test.sv
// Word-organised simulation RAM: one byte-strobed write port and one registered read port.
// Read and write at the same address on the same edge return the pre-write contents.
module sim_ram_for_test #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     raddr,
    input  logic [ADDR_WIDTH-1:0]     waddr,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH-1:0]     rdata
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    // Two-state storage so every word starts at zero; reset never touches the array.
    bit [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: tb/tb_sim_ram_for_test.sv
// Directed bench for sim_ram_for_test; expected read data is queued at issue time
// and a separate monitor compares it one edge later.
module tb_sim_ram_for_test;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clock;
    logic          reset;
    logic [AW-1:0] raddr;
    logic [AW-1:0] waddr;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    sim_ram_for_test #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock),
        .reset(reset),
        .raddr(raddr),
        .waddr(waddr),
        .wstrb(wstrb),
        .wdata(wdata),
        .rdata(rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] exp;
        string         name;
    } exp_t;

    exp_t scb[$];
    logic tb_rd;
    int   checks   = 0;
    int   failures = 0;

    // Monitor: a read issued before an edge is compared on the following falling edge.
    initial begin
        logic pend;
        exp_t e;
        forever begin
            @(posedge clock);
            pend = tb_rd;
            @(negedge clock);
            if (pend) begin
                checks++;
                if (scb.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_underflow: rdata=%h expected=<none>", rdata);
                end else begin
                    e = scb.pop_front();
                    if (rdata !== e.exp) begin
                        failures++;
                        $display("FAIL %s: rdata=%h expected=%h", e.name, rdata, e.exp);
                    end
                end
            end
        end
    end

    task automatic cyc(input logic rst, input logic rd, input logic [AW-1:0] ra,
                       input logic [AW-1:0] wa, input logic [SW-1:0] ws,
                       input logic [DW-1:0] wd, input logic [DW-1:0] exp,
                       input string name);
        exp_t e;
        reset = rst;
        tb_rd = rd;
        raddr = ra;
        waddr = wa;
        wstrb = ws;
        wdata = wd;
        if (rd) begin
            e.exp  = exp;
            e.name = name;
            scb.push_back(e);
        end
        @(negedge clock);
    endtask

    task automatic wr(input logic [AW-1:0] wa, input logic [SW-1:0] ws, input logic [DW-1:0] wd);
        cyc(1'b0, 1'b0, '0, wa, ws, wd, '0, "");
    endtask

    task automatic rd(input logic [AW-1:0] ra, input logic [DW-1:0] exp, input string name);
        cyc(1'b0, 1'b1, ra, '0, '0, 32'h0BAD_F00D, exp, name);
    endtask

    initial begin
        reset = 1'b1;
        tb_rd = 1'b0;
        raddr = '0;
        waddr = '0;
        wstrb = '0;
        wdata = '0;

        for (int i = 0; i < 10; i++)
            cyc(1'b1, 1'b1, '0, '0, '0, '0, 32'h0, "reset_hold");
        rd(13'd0, 32'h0000_0000, "after_reset_word0");

        wr(13'd0, 4'hF, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b0, '0, '0, '0, '0, '0, "");
        rd(13'd0, 32'hDEAD_BEEF, "full_word");

        wr(13'd1, 4'h3, 32'hDEAD_BEEF);
        rd(13'd1, 32'h0000_BEEF, "low_half");
        wr(13'd2, 4'hC, 32'hDEAD_BEEF);
        rd(13'd2, 32'hDEAD_0000, "high_half");
        wr(13'd3, 4'h1, 32'hDEAD_BEEF);
        rd(13'd3, 32'h0000_00EF, "byte0");
        wr(13'd4, 4'h2, 32'hDEAD_BEEF);
        rd(13'd4, 32'h0000_BE00, "byte1");

        wr(13'd5, 4'hF, 32'h1122_3344);
        cyc(1'b0, 1'b1, 13'd5, 13'd5, 4'h5, 32'hAABB_CCDD, 32'h1122_3344, "read_first");
        rd(13'd5, 32'h11BB_33DD, "merge_0101");

        cyc(1'b0, 1'b1, 13'd1, 13'd6, 4'hF, 32'h1234_5678, 32'h0000_BEEF, "indep_read");
        rd(13'd6, 32'h1234_5678, "indep_write");

        wr(13'd0, 4'h0, 32'hFFFF_FFFF);
        rd(13'd0, 32'hDEAD_BEEF, "zero_strobe");

        wr(13'd8191, 4'h8, 32'hA5FF_FFFF);
        rd(13'd8191, 32'hA500_0000, "top_addr_byte3");
        rd(13'd8190, 32'h0000_0000, "untouched_word");

        cyc(1'b1, 1'b1, 13'd0, 13'd0, 4'hF, 32'hFFFF_FFFF, 32'h0, "reset_mid_write");
        cyc(1'b1, 1'b1, 13'd5, 13'd5, 4'hF, 32'hFFFF_FFFF, 32'h0, "reset_mid_write2");
        rd(13'd0, 32'hDEAD_BEEF, "reset_kept_word0");
        rd(13'd5, 32'h11BB_33DD, "reset_kept_word5");

        tb_rd = 1'b0;
        wstrb = '0;
        for (int i = 0; i < 20 && scb.size() != 0; i++) @(negedge clock);
        checks++;
        if (scb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", scb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t expected=finish before 100000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
